// File: rtl/fifo_read_ctrl.sv
// fifo_read_ctrl: read-domain half of an asynchronous FIFO with a 2-entry valid/ready output buffer.
// Ports:
//   rclk, rrst_n          read clock; active-low reset (asserts asynchronously, releases on rclk)
//   wptr                  Gray write pointer from the write domain
//   rptr                  registered Gray read pointer back to the write domain
//   raddr, ren            binary RAM read address and read enable
//   rdata_mem             registered RAM read data, valid the cycle after ren
//   m_data/m_valid/m_ready  head-of-queue stream to the consumer
//   rempty, raempty, rcount  unfetched-word status in the RAM
module fifo_read_ctrl #(
    parameter int ASIZE         = 4,
    parameter int DSIZE         = 8,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic [ASIZE:0]   wptr,
    output logic [ASIZE:0]   rptr,
    output logic [ASIZE-1:0] raddr,
    output logic             ren,
    input  logic [DSIZE-1:0] rdata_mem,
    output logic [DSIZE-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             rempty,
    output logic             raempty,
    output logic [ASIZE:0]   rcount
);
    logic [1:0]       rst_sync_q;
    logic             rst_n_int;
    logic [ASIZE:0]   rq1_wptr_q, rq2_wptr_q, wbin_s;
    logic [ASIZE:0]   rbin_q, rbin_d, rptr_q;
    logic             rempty_q, rempty_d;
    logic             inflight_q;
    logic [1:0]       occ_q, occ_d, used;
    logic [DSIZE-1:0] head_q, head_d, skid_q, skid_d;
    logic             pop;

    // Reset asserts immediately but its release is re-timed to rclk.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) rst_sync_q <= '0;
        else         rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n_int = rst_sync_q[1];

    // Bit i of a Gray-to-binary conversion is the XOR of all Gray bits at or above i.
    for (genvar g = 0; g <= ASIZE; g++) begin : g_g2b
        assign wbin_s[g] = ^(rq2_wptr_q >> g);
    end

    assign pop     = m_valid & m_ready;
    // Slots committed for the next cycle: held words plus the word landing now, minus the one leaving.
    assign used    = occ_q + 2'(inflight_q) - 2'(pop);
    assign ren     = !rempty_q && !used[1];
    assign rbin_d  = rbin_q + {{ASIZE{1'b0}}, ren};
    assign rempty_d = ((rbin_d ^ (rbin_d >> 1)) == rq2_wptr_q);

    assign raddr   = rbin_q[ASIZE-1:0];
    assign rptr    = rptr_q;
    assign rempty  = rempty_q;
    assign rcount  = wbin_s - rbin_q;
    assign raempty = rcount <= (ASIZE+1)'(AEMPTY_THRESH);
    assign m_valid = occ_q != 2'd0;
    assign m_data  = head_q;

    // Head always holds the oldest word; skid only fills when head is busy and not leaving.
    always_comb begin
        occ_d  = used;
        head_d = pop ? ((occ_q == 2'd2) ? skid_q : (inflight_q ? rdata_mem : head_q))
                     : ((occ_q == 2'd0 && inflight_q) ? rdata_mem : head_q);
        skid_d = (inflight_q && occ_q == 2'd1 && !pop) ? rdata_mem : skid_q;
    end

    always_ff @(posedge rclk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            rq1_wptr_q <= '0;
            rq2_wptr_q <= '0;
            rbin_q     <= '0;
            rptr_q     <= '0;
            rempty_q   <= 1'b1;
            inflight_q <= 1'b0;
            occ_q      <= '0;
            head_q     <= '0;
            skid_q     <= '0;
        end else begin
            rq1_wptr_q <= wptr;
            rq2_wptr_q <= rq1_wptr_q;
            rbin_q     <= rbin_d;
            rptr_q     <= rbin_d ^ (rbin_d >> 1);
            rempty_q   <= rempty_d;
            inflight_q <= ren;
            occ_q      <= occ_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
        end
    end
endmodule

// File: tb/tb_fifo_read_ctrl.sv
// tb_fifo_read_ctrl: directed bench for fifo_read_ctrl with a write-side model and registered RAM.
module tb_fifo_read_ctrl;
    logic       rclk = 1'b0;
    logic       rrst_n, ren, m_valid, m_ready, rempty, raempty;
    logic [4:0] wptr, rptr, rcount, wbin;
    logic [3:0] raddr;
    logic [7:0] rdata_mem, m_data;
    logic [7:0] mem [16];
    logic [7:0] exp_q [$];
    int         tests = 0, failed = 0, wcnt = 0;
    int         n, gaps, toggles, written;
    logic       started, prev_msb, stale;

    fifo_read_ctrl #(.ASIZE(4), .DSIZE(8), .AEMPTY_THRESH(2)) dut (
        .rclk(rclk), .rrst_n(rrst_n), .wptr(wptr), .rptr(rptr), .raddr(raddr), .ren(ren),
        .rdata_mem(rdata_mem), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .rempty(rempty), .raempty(raempty), .rcount(rcount)
    );

    always #5 rclk = ~rclk;

    always @(posedge rclk) if (ren) rdata_mem <= mem[raddr];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, tests=%0d failed=%0d", tests, failed);
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge rclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_word;
        logic [7:0] d;
        d = 8'(wcnt * 37 + 5);
        mem[wbin[3:0]] = d;
        exp_q.push_back(d);
        wbin = wbin + 5'd1;
        wptr = wbin ^ (wbin >> 1);
        wcnt++;
    endtask

    task automatic expect_word(input string tag);
        tests++;
        assert (exp_q.size() != 0) else begin
            failed++;
            $error("FAIL %s: observed word %0h expected no word", tag, m_data);
        end
        if (exp_q.size() != 0) begin
            tests--;
            chk(tag, m_data, exp_q.pop_front());
        end
    endtask

    initial begin
        rrst_n = 1'b1; m_ready = 1'b0; wptr = '0; wbin = '0; rdata_mem = '0;
        #3 rrst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wptr = 5'($urandom);
            tick;
            chk("rst_rempty", rempty, 1);
            chk("rst_raempty", raempty, 1);
            chk("rst_mvalid", m_valid, 0);
            chk("rst_rptr", rptr, 0);
            chk("rst_ren", ren, 0);
            chk("rst_rcount", rcount, 0);
        end
        wptr = '0;
        tick;
        rrst_n = 1'b1;
        repeat (4) tick;
        chk("idle_rempty", rempty, 1);
        chk("idle_mvalid", m_valid, 0);

        // single word: valid appears after the 5th edge, for one cycle
        m_ready = 1'b1;
        push_word;
        started = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            tick;
            if (m_valid) started = 1'b1;
            if (e == 3) chk("sw_ren_e3", ren, 1);
        end
        chk("sw_early_valid", started, 0);
        chk("sw_rptr", rptr, 1);
        chk("sw_rempty", rempty, 1);
        chk("sw_ren_after", ren, 0);
        tick;
        chk("sw_valid_e5", m_valid, 1);
        expect_word("sw_data");
        tick;
        chk("sw_valid_e6", m_valid, 0);

        // streaming 40 words across pointer wrap
        n = 0; gaps = 0; toggles = 0; written = 0; started = 1'b0; prev_msb = rptr[4];
        for (int c = 0; c < 200 && n < 40; c++) begin
            if (written < 40 && exp_q.size() < 14) begin
                push_word;
                written++;
            end
            tick;
            if (rptr[4] != prev_msb) toggles++;
            prev_msb = rptr[4];
            if (m_valid) begin
                started = 1'b1;
                expect_word("stream_data");
                n++;
            end else if (started && n < 40) gaps++;
        end
        chk("stream_count", n, 40);
        chk("stream_gaps", gaps, 0);
        chk("stream_msb_toggles", toggles, 2);
        repeat (3) tick;
        chk("stream_end_empty", rempty, 1);

        // backpressure
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push_word;
            tick;
        end
        for (int i = 0; i < 10; i++) begin
            tick;
            if (m_valid) chk("bp_hold_data", m_data, exp_q[0]);
        end
        chk("bp_valid", m_valid, 1);
        chk("bp_rcount", rcount, 6);
        chk("bp_ren", ren, 0);
        m_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 30 && n < 8; c++) begin
            if (m_valid) begin
                expect_word("bp_data");
                n++;
            end
            tick;
        end
        chk("bp_count", n, 8);
        repeat (4) tick;
        chk("bp_end_empty", rempty, 1);
        chk("bp_end_valid", m_valid, 0);

        // almost-empty threshold and full occupancy
        m_ready = 1'b0;
        repeat (2) begin push_word; tick; end
        repeat (8) tick;
        chk("thr_full_valid", m_valid, 1);
        chk("thr_rcount0", rcount, 0);
        repeat (3) begin push_word; tick; end
        repeat (4) tick;
        chk("thr_rcount3", rcount, 3);
        chk("thr_raempty3", raempty, 0);
        expect_word("thr_pop_data");
        m_ready = 1'b1;
        tick;
        m_ready = 1'b0;
        chk("thr_rcount2", rcount, 2);
        chk("thr_raempty2", raempty, 1);
        repeat (14) begin push_word; tick; end
        repeat (4) tick;
        chk("thr_rcount16", rcount, 16);
        chk("thr_raempty16", raempty, 0);
        chk("thr_rempty16", rempty, 0);
        chk("thr_ren16", ren, 0);
        m_ready = 1'b1;
        for (int c = 0; c < 80 && exp_q.size() > 0; c++) begin
            if (m_valid) expect_word("thr_drain_data");
            tick;
        end
        chk("thr_drain_left", exp_q.size(), 0);
        repeat (3) tick;

        // reset while a word is held and another fetch is in flight
        repeat (4) begin push_word; tick; end
        for (int c = 0; c < 20 && !m_valid; c++) tick;
        chk("mr_valid_before", m_valid, 1);
        #2 rrst_n = 1'b0;
        #1;
        chk("mr_mvalid", m_valid, 0);
        chk("mr_ren", ren, 0);
        chk("mr_mdata", m_data, 0);
        chk("mr_rempty", rempty, 1);
        chk("mr_raempty", raempty, 1);
        chk("mr_rcount", rcount, 0);
        chk("mr_rptr", rptr, 0);
        wbin = '0; wptr = '0; exp_q.delete();
        repeat (3) tick;
        rrst_n = 1'b1;
        stale = 1'b0;
        repeat (10) begin
            tick;
            if (m_valid) stale = 1'b1;
        end
        chk("mr_no_stale", stale, 0);
        repeat (2) begin push_word; tick; end
        n = 0;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            if (m_valid) begin
                expect_word("mr_data");
                n++;
            end
            tick;
        end
        chk("mr_count", n, 2);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
